// File: rtl/fir_mac_scheduler_if.sv
// Bus bundle between fir_mac_scheduler (master) and its channel FIFOs / shared MAC engine (slave).
interface fir_mac_scheduler_if #(
   parameter int DATA_WIDTH = 32,
   parameter int TAPS       = 32,
   parameter int NUM_CH     = 2
);
   localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH*DATA_WIDTH-1:0] ch_din;
   logic [NUM_CH-1:0]            ch_empty;
   logic [NUM_CH-1:0]            ch_rd_en;
   logic [NUM_CH*DATA_WIDTH-1:0] ch_dout;
   logic [NUM_CH-1:0]            ch_full;
   logic [NUM_CH-1:0]            ch_wr_en;
   logic                         mac_en;
   logic                         mac_clr;
   logic [DATA_WIDTH-1:0]        mac_x;
   logic [TW-1:0]                mac_tap_idx;
   logic [DATA_WIDTH-1:0]        mac_acc;
   logic [GW-1:0]                grant;
   logic                         busy;

   modport master (
      input  ch_din, ch_empty, ch_full, mac_acc,
      output ch_rd_en, ch_dout, ch_wr_en, mac_en, mac_clr, mac_x, mac_tap_idx, grant, busy
   );

   modport slave (
      output ch_din, ch_empty, ch_full, mac_acc,
      input  ch_rd_en, ch_dout, ch_wr_en, mac_en, mac_clr, mac_x, mac_tap_idx, grant, busy
   );
endinterface

// File: rtl/fir_mac_scheduler.sv
// Round-robin scheduler sharing one external MAC engine among NUM_CH decimating FIR channels.
// Optional FIR_SCHED_STATS_EN adds per-channel completed-write counters on port ch_frames.
module fir_mac_scheduler #(
   parameter int DATA_WIDTH = 32,
   parameter int TAPS       = 32,
   parameter int DECIMATION = 8,
   parameter int NUM_CH     = 2
) (
   input  logic                 clock,
   input  logic                 reset,
`ifdef FIR_SCHED_STATS_EN
   output logic [NUM_CH*16-1:0] ch_frames,
`endif
   fir_mac_scheduler_if.master  bus
);

   localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int SW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_MAC,
      S_DRAIN,
      S_WRITE
   } state_t;

   state_t                state, state_nx;
   logic [GW-1:0]         g;
   logic [GW-1:0]         last_grant;
   logic [SW-1:0]         samp_cnt;
   logic [TW-1:0]         k;
   logic [DATA_WIDTH-1:0] x    [NUM_CH][TAPS];
   logic [DATA_WIDTH-1:0] din  [NUM_CH];
   logic [DATA_WIDTH-1:0] dout [NUM_CH];
   logic [DATA_WIDTH-1:0] result;
   logic [NUM_CH-1:0]     wr_en;

   logic                  hit;
   logic [GW-1:0]         pick;
   logic                  pop;
   logic                  last_pop;
   logic                  last_tap;
   logic                  mac_on;
   logic                  write_go;

   function automatic logic [GW-1:0] rr_next(input logic [GW-1:0] base, input int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= NUM_CH) s = s - NUM_CH;
      return GW'(s);
   endfunction

   always_comb begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
         din[ch] = bus.ch_din[ch*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // First non-empty channel after the last one served; the last served is checked last.
   always_comb begin
      hit  = 1'b0;
      pick = '0;
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
         if (!hit && !bus.ch_empty[rr_next(last_grant, i)]) begin
            hit  = 1'b1;
            pick = rr_next(last_grant, i);
         end
      end
   end

   always_comb begin
      pop      = reset && (state == S_LOAD) && !bus.ch_empty[g];
      last_pop = pop && (samp_cnt == SW'(DECIMATION - 1));
      last_tap = (k == TW'(TAPS - 1));
      mac_on   = reset && (state == S_MAC);
      write_go = (state == S_WRITE) && !bus.ch_full[g];
   end

   always_ff @(posedge clock) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Combinational outputs are gated by reset so they read 0 while reset is held.
   always_comb begin
      state_nx        = state;
      bus.ch_rd_en    = '0;
      bus.mac_en      = mac_on;
      bus.mac_clr     = 1'b0;
      bus.mac_x       = '0;
      bus.mac_tap_idx = '0;
      bus.busy        = reset && (state != S_IDLE);
      bus.grant       = reset ? g : '0;

      if (pop) bus.ch_rd_en[g] = 1'b1;

      if (mac_on) begin
         bus.mac_clr     = (k == '0);
         bus.mac_x       = x[g][k];
         bus.mac_tap_idx = TW'(TAPS - 1) - k;
      end

      unique case (state)
         S_IDLE:  if (hit)       state_nx = S_LOAD;
         S_LOAD:  if (last_pop)  state_nx = S_MAC;
         S_MAC:   if (last_tap)  state_nx = S_DRAIN;
         S_DRAIN:                state_nx = S_WRITE;
         S_WRITE: if (write_go)  state_nx = S_IDLE;
         default:                state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         g          <= '0;
         last_grant <= GW'(NUM_CH - 1);
         samp_cnt   <= '0;
         k          <= '0;
         result     <= '0;
         wr_en      <= '0;
         for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            dout[ch] <= '0;
            for (int unsigned t = 0; t < TAPS; t++) begin
               x[ch][t] <= '0;
            end
         end
      end else begin
         wr_en <= '0;

         if ((state == S_IDLE) && hit) g <= pick;

         if (pop) begin
            x[g][0] <= din[g];
            for (int unsigned t = 1; t < TAPS; t++) begin
               x[g][t] <= x[g][t-1];
            end
            samp_cnt <= last_pop ? '0 : samp_cnt + SW'(1);
         end

         if (state == S_MAC) k <= last_tap ? '0 : k + TW'(1);

         if (state == S_DRAIN) result <= bus.mac_acc;

         if (write_go) begin
            wr_en[g]   <= 1'b1;
            dout[g]    <= result;
            last_grant <= g;
         end
      end
   end

   always_comb begin
      bus.ch_dout  = '0;
      bus.ch_wr_en = wr_en;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
         bus.ch_dout[ch*DATA_WIDTH +: DATA_WIDTH] = dout[ch];
      end
   end

`ifdef FIR_SCHED_STATS_EN
   logic [15:0] frames [NUM_CH];

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            frames[ch] <= '0;
         end
      end else if (write_go) begin
         frames[g] <= frames[g] + 16'd1;
      end
   end

   always_comb begin
      ch_frames = '0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
         ch_frames[ch*16 +: 16] = frames[ch];
      end
   end
`endif

   a_rd_onehot: assert property (@(posedge clock) disable iff (!reset) $onehot0(bus.ch_rd_en));
   a_wr_onehot: assert property (@(posedge clock) disable iff (!reset) $onehot0(bus.ch_wr_en));
   a_mac_busy:  assert property (@(posedge clock) disable iff (!reset) bus.mac_en |-> bus.busy);

endmodule
